// File: rtl/arb_pkg.sv
// Shared definitions for the arbiter client.
//   client_state_e : FSM encoding (IDLE=0, REQ=1, XFER=2, REL=3)
//   DEF_LEN_W      : default width of the command length field
//   DEF_TIMEOUT    : default grant wait limit, in cycles
//   WAIT_W         : width of the grant wait counter (covers TIMEOUT up to 255)
package arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    XFER = 2'd2,
    REL  = 2'd3
  } client_state_e;

  localparam int DEF_LEN_W   = 4;
  localparam int DEF_TIMEOUT = 16;
  localparam int WAIT_W      = 8;

endpackage

// File: rtl/arb_client_if.sv
// Command and arbiter handshake bundle for arb_client.
//   cmd_valid/cmd_len/cmd_ready : command push (cmd_len = beats - 1)
//   req/gnt                     : arbiter request / grant
//   xfer_active/xfer_last       : per-beat strobes
//   done/err/busy               : completion, abort, activity status
// modport master : the client (drives req and the status outputs)
// modport slave  : the environment (command source + arbiter)
interface arb_client_if
  import arb_pkg::*;
#(
  parameter int LEN_W = DEF_LEN_W
);
  logic             cmd_valid;
  logic [LEN_W-1:0] cmd_len;
  logic             cmd_ready;
  logic             req;
  logic             gnt;
  logic             xfer_active;
  logic             xfer_last;
  logic             done;
  logic             err;
  logic             busy;

  modport master (
    input  cmd_valid, cmd_len, gnt,
    output cmd_ready, req, xfer_active, xfer_last, done, err, busy
  );

  modport slave (
    output cmd_valid, cmd_len, gnt,
    input  cmd_ready, req, xfer_active, xfer_last, done, err, busy
  );
endinterface

// File: rtl/arb_client_fifo.sv
// Two-entry command queue.
//   clock, reset : rising-edge clock, synchronous active-high reset
//   push, din    : write an entry (ignored when full)
//   pop, dout    : read the head entry (ignored when empty)
//   empty, full  : occupancy flags, derived from registered state only
// A push and a pop in the same cycle both take effect.
module arb_client_fifo #(
  parameter int W = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         empty,
  output logic         full
);
  logic [W-1:0] mem [2];
  logic         wr_ptr, rd_ptr;
  logic [1:0]   count;
  logic         push_ok, pop_ok;

  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push_ok) wr_ptr <= ~wr_ptr;
      if (pop_ok)  rd_ptr <= ~rd_ptr;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset; count governs validity.
  always_ff @(posedge clock) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

  assign dout  = mem[rd_ptr];
  assign empty = (count == 2'd0);
  assign full  = (count == 2'd2);
endmodule

// File: rtl/arb_client.sv
// Arbiter client: queues transfer commands, requests the bus, counts granted
// beats, and releases the bus once grant drops.
//   clock, reset : rising-edge clock, synchronous active-high reset
//   bus          : arb_client_if.master (command push, req/gnt, status)
// Parameters: LEN_W (command length width), TIMEOUT (grant wait limit, 4..255).
module arb_client
  import arb_pkg::*;
#(
  parameter int LEN_W   = DEF_LEN_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic         clock,
  input  logic         reset,
  arb_client_if.master bus
);
  client_state_e     state, state_nx;
  logic [LEN_W-1:0]  beat_cnt;
  logic [WAIT_W-1:0] wait_cnt;

  logic             fifo_empty, fifo_full, fifo_pop, fifo_push;
  logic [LEN_W-1:0] fifo_head;

  logic req_q, done_q, err_q;
  logic req_d, done_d, err_d;
  logic beat, last_beat, timeout_hit, grant_lost;

  assign fifo_push = bus.cmd_valid && !fifo_full;
  // Head is consumed as the FSM leaves IDLE.
  assign fifo_pop  = (state == IDLE) && !fifo_empty;

  arb_client_fifo #(.W(LEN_W)) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (fifo_push),
    .din   (bus.cmd_len),
    .pop   (fifo_pop),
    .dout  (fifo_head),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  assign beat        = (state == XFER) && bus.gnt;
  assign last_beat   = beat && (beat_cnt == '0);
  assign grant_lost  = (state == XFER) && !bus.gnt;
  assign timeout_hit = (state == REQ) && !bus.gnt &&
                       (wait_cnt == WAIT_W'(TIMEOUT - 1));

  // State register and registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= IDLE;
      req_q  <= 1'b0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      state  <= state_nx;
      req_q  <= req_d;
      done_q <= done_d;
      err_q  <= err_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (!fifo_empty) state_nx = REQ;
      REQ: begin
        if (bus.gnt)          state_nx = XFER;
        else if (timeout_hit) state_nx = REL;
      end
      XFER: if (grant_lost || last_beat) state_nx = REL;
      // Hold off the next request until the arbiter has let go of grant.
      REL:  if (!bus.gnt) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Output logic; req/done/err are registered one cycle later.
  always_comb begin
    req_d  = (state_nx == REQ) || (state_nx == XFER);
    done_d = last_beat;
    err_d  = timeout_hit || grant_lost;
  end

  // Beat and wait counters.
  always_ff @(posedge clock) begin
    if (reset) begin
      beat_cnt <= '0;
      wait_cnt <= '0;
    end else begin
      if (fifo_pop)
        beat_cnt <= fifo_head;
      else if (beat && (beat_cnt != '0))
        beat_cnt <= beat_cnt - 1'b1;

      if (state != REQ)
        wait_cnt <= '0;
      else if (!bus.gnt)
        wait_cnt <= wait_cnt + 1'b1;
    end
  end

  assign bus.cmd_ready   = !fifo_full;
  assign bus.req         = req_q;
  assign bus.xfer_active = beat;
  assign bus.xfer_last   = last_beat;
  assign bus.done        = done_q;
  assign bus.err         = err_q;
  assign bus.busy        = (state != IDLE) || !fifo_empty;
endmodule

// File: tb/tb_arb_client.sv
// Self-checking bench for arb_client: directed scenarios plus a randomized
// phase, every cycle compared against a transaction-level model.
module tb_arb_client;
  localparam int LEN_W   = 4;
  localparam int TIMEOUT = 16;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  arb_client_if #(.LEN_W(LEN_W)) bus ();
  arb_client #(.LEN_W(LEN_W), .TIMEOUT(TIMEOUT)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0, errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- arbiter behaviour (stimulus) ----------------
  int grant_delay = 0, hold_cycles = 0, rel_delay = 0;
  bit never_grant = 0, rand_mode = 0;
  int req_age = 0, gnt_age = 0, rel_age = 0;

  task automatic arb_step();
    if (bus.req) begin
      rel_age = 0;
      if (!bus.gnt) begin
        if (req_age == 0 && rand_mode) begin
          grant_delay = $urandom_range(0, 18);
          hold_cycles = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 6) : 0;
          rel_delay   = $urandom_range(0, 2);
        end
        if (!never_grant && gnt_age == 0 && req_age >= grant_delay) bus.gnt = 1'b1;
        req_age++;
      end else begin
        gnt_age++;
        if (hold_cycles > 0 && gnt_age >= hold_cycles) bus.gnt = 1'b0;
      end
    end else begin
      req_age = 0;
      gnt_age = 0;
      if (bus.gnt) begin
        if (rel_age >= rel_delay) bus.gnt = 1'b0;
        else rel_age++;
      end
    end
  endtask

  task automatic tick(input bit r, input bit v, input int l);
    @(negedge clock);
    reset         = r;
    bus.cmd_valid = v;
    bus.cmd_len   = LEN_W'(l);
    arb_step();
  endtask

  // ---------------- reference model ----------------
  // A command is either waiting for grant, streaming its remaining beats,
  // or finished and waiting for the arbiter to release grant.
  int mq[$];
  bit m_hold = 0, m_gr = 0, m_rel = 0, m_done = 0, m_err = 0;
  int m_left = 0, m_wait = 0;
  bit chk_en = 0;

  // observation counters for literal expectations
  int n_beat, n_last, n_done, n_err, n_req, low_run, last_gap;
  bit seen_req;

  task automatic clear_stats();
    n_beat = 0; n_last = 0; n_done = 0; n_err = 0; n_req = 0;
    low_run = 0; last_gap = -1; seen_req = 0;
  endtask

  initial begin : compare
    bit acc;
    bit exp_active;
    forever begin
      @(negedge clock);
      #2;
      if (chk_en) begin
        exp_active = m_hold && m_gr && bus.gnt;
        chk("cmd_ready",   bus.cmd_ready,   mq.size() < 2);
        chk("req",         bus.req,         m_hold);
        chk("xfer_active", bus.xfer_active, exp_active);
        chk("xfer_last",   bus.xfer_last,   exp_active && (m_left == 1));
        chk("done",        bus.done,        m_done);
        chk("err",         bus.err,         m_err);
        chk("busy",        bus.busy,        m_hold || m_rel || (mq.size() > 0));
        if (bus.xfer_active === 1'b1) n_beat++;
        if (bus.xfer_last === 1'b1)   n_last++;
        if (bus.done === 1'b1)        n_done++;
        if (bus.err === 1'b1)         n_err++;
        if (bus.req === 1'b1) begin
          n_req++;
          if (seen_req && low_run > 0) last_gap = low_run;
          low_run  = 0;
          seen_req = 1;
        end else if (seen_req) low_run++;
      end
      // advance the model across the coming clock edge
      if (reset) begin
        mq.delete();
        m_hold = 0; m_gr = 0; m_rel = 0; m_done = 0; m_err = 0;
        m_left = 0; m_wait = 0;
        chk_en = 1;
      end else begin
        acc = bus.cmd_valid && (mq.size() < 2);
        m_done = 0;
        m_err  = 0;
        if (m_hold && !m_gr) begin
          if (bus.gnt) m_gr = 1;
          else if (m_wait == TIMEOUT - 1) begin m_hold = 0; m_rel = 1; m_err = 1; end
          else m_wait++;
        end else if (m_hold) begin
          if (!bus.gnt)          begin m_hold = 0; m_rel = 1; m_err = 1; end
          else if (m_left == 1)  begin m_hold = 0; m_rel = 1; m_done = 1; end
          else m_left--;
        end else if (m_rel) begin
          if (!bus.gnt) m_rel = 0;
        end else if (mq.size() > 0) begin
          m_left = mq.pop_front() + 1;
          m_hold = 1; m_gr = 0; m_wait = 0;
        end
        if (acc) mq.push_back(int'(bus.cmd_len));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic arb_cfg(input int gd, input int hc, input int rd, input bit ng);
    grant_delay = gd; hold_cycles = hc; rel_delay = rd; never_grant = ng; rand_mode = 0;
  endtask

  initial begin : stim
    logic rdy [4];
    reset = 1'b1; bus.cmd_valid = 1'b0; bus.cmd_len = '0; bus.gnt = 1'b0;
    clear_stats();
    tick(1, 0, 0);
    tick(1, 0, 0);
    tick(0, 0, 0);
    chk("rst_req",       bus.req,       0);
    chk("rst_busy",      bus.busy,      0);
    chk("rst_cmd_ready", bus.cmd_ready, 1);
    chk("rst_done_err",  {bus.done, bus.err}, 0);

    // len 3, grant a couple of cycles after req, held
    arb_cfg(2, 0, 0, 0); clear_stats();
    tick(0, 1, 3);
    repeat (30) tick(0, 0, 0);
    chk("t1_beats", n_beat, 4);
    chk("t1_last",  n_last, 1);
    chk("t1_done",  n_done, 1);
    chk("t1_err",   n_err,  0);

    // len 0, never granted: full timeout then back to idle
    arb_cfg(0, 0, 0, 1); clear_stats();
    tick(0, 1, 0);
    repeat (30) tick(0, 0, 0);
    chk("t2_req_cycles", n_req, TIMEOUT);
    chk("t2_err",        n_err, 1);
    chk("t2_done",       n_done, 0);
    chk("t2_idle",       bus.busy, 0);

    // len 7, grant lost after 3 beats
    arb_cfg(0, 4, 0, 0); clear_stats();
    tick(0, 1, 7);
    repeat (30) tick(0, 0, 0);
    chk("t3_beats", n_beat, 3);
    chk("t3_err",   n_err,  1);
    chk("t3_done",  n_done, 0);

    // back-to-back commands with grant held low
    arb_cfg(0, 0, 0, 1); clear_stats();
    for (int i = 0; i < 4; i++) begin
      tick(0, 1, i);
      rdy[i] = bus.cmd_ready;
    end
    chk("t4_rdy0", rdy[0], 1);
    chk("t4_rdy1", rdy[1], 1);
    chk("t4_rdy2", rdy[2], 1);
    chk("t4_rdy3", rdy[3], 0);
    repeat (80) tick(0, 0, 0);
    chk("t4_err", n_err, 3);

    // grant lingers 2 cycles after req falls, second command queued
    arb_cfg(0, 0, 2, 0); clear_stats();
    tick(0, 1, 0);
    tick(0, 1, 1);
    repeat (25) tick(0, 0, 0);
    chk("t5_gap",  last_gap, 4);
    chk("t5_done", n_done,   2);

    // reset in the middle of a transfer with a command queued
    arb_cfg(0, 0, 0, 0); clear_stats();
    tick(0, 1, 7);
    tick(0, 1, 2);
    repeat (4) tick(0, 0, 0);
    chk("t6_mid_xfer", bus.xfer_active, 1);
    tick(1, 0, 0);
    tick(0, 0, 0);
    chk("t6_req",       bus.req,       0);
    chk("t6_busy",      bus.busy,      0);
    chk("t6_cmd_ready", bus.cmd_ready, 1);
    repeat (10) tick(0, 0, 0);
    chk("t6_done", n_done, 0);
    chk("t6_err",  n_err,  0);

    // randomized traffic, arbiter behaviour and occasional resets
    never_grant = 0; hold_cycles = 0; rand_mode = 1;
    for (int c = 0; c < 2000; c++)
      tick($urandom_range(0, 399) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 15));
    arb_cfg(0, 0, 0, 0);
    repeat (100) tick(0, 0, 0);
    chk("drain_busy", bus.busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
